// File: rtl/logic_gate_sim.sv
// logic_gate_sim
//   Multi-channel 2-input gate simulator. A shared stimulus pair {b,a} steps
//   through 00,01,10,11 at a rate set by div. Each channel applies its own
//   run-time selected gate to that pair. The result goes through a DELAY-deep
//   register pipeline before it reaches gate_out. Per-channel output
//   transitions and enabled cycles are counted for readout.
//
// Ports
//   clock       : system clock, all logic on the rising edge
//   reset_n     : synchronous active-low reset, highest priority
//   enable      : 1 = advance the simulation, 0 = freeze everything but clear
//   clear       : synchronous clear of toggle_cnt and cycle_cnt only
//   div         : stimulus hold time, pattern advances every div+1 enabled cycles
//   gate_sel    : per-channel op, channel i at [3i+2:3i]
//                 0 NOT a, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF a
//   stim_ab     : current stimulus {b,a}
//   gate_out    : delayed gate result per channel
//   toggle_cnt  : saturating transition count of gate_out[i] at [CNT_W*i +: CNT_W]
//   cycle_cnt   : enabled cycles since reset or clear, wraps at 2^32

module logic_gate_sim #(
  parameter int CHANNELS = 4,
  parameter int DELAY    = 2,
  parameter int CNT_W    = 16,
  parameter int STIM_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [STIM_W-1:0]         div,
  input  logic [3*CHANNELS-1:0]     gate_sel,
  output logic [1:0]                stim_ab,
  output logic [CHANNELS-1:0]       gate_out,
  output logic [CNT_W*CHANNELS-1:0] toggle_cnt,
  output logic [31:0]               cycle_cnt
);

  localparam logic [STIM_W-1:0] PRESC_ONE = {{(STIM_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [STIM_W-1:0]   presc;
  logic [CHANNELS-1:0] gateVal;
  logic [CHANNELS-1:0] stage [DELAY];
  logic [CHANNELS-1:0] outNext;
  logic [CNT_W-1:0]    togCnt [CHANNELS];

  // Combinational gate evaluation of every channel against the current
  // stimulus; this value is what the first pipeline stage captures.
  always_comb begin
    gateVal = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (gate_sel[3*i +: 3])
        3'd0:    gateVal[i] = ~stim_ab[0];
        3'd1:    gateVal[i] = stim_ab[0] & stim_ab[1];
        3'd2:    gateVal[i] = stim_ab[0] | stim_ab[1];
        3'd3:    gateVal[i] = ~(stim_ab[0] & stim_ab[1]);
        3'd4:    gateVal[i] = ~(stim_ab[0] | stim_ab[1]);
        3'd5:    gateVal[i] = stim_ab[0] ^ stim_ab[1];
        3'd6:    gateVal[i] = ~(stim_ab[0] ^ stim_ab[1]);
        default: gateVal[i] = stim_ab[0];
      endcase
    end
  end

  // The value the last stage will take on the next enabled edge; comparing
  // it with the current output tells us whether a transition is about to
  // happen. With a single stage that value comes straight from the gates.
  generate
    if (DELAY == 1) begin : gNextDirect
      assign outNext = gateVal;
    end else begin : gNextPipe
      assign outNext = stage[DELAY-2];
    end
  endgenerate

  assign gate_out = stage[DELAY-1];

  // Pack the per-channel counters onto the flat readout bus.
  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : gPack
      assign toggle_cnt[CNT_W*g +: CNT_W] = togCnt[g];
    end
  endgenerate

  // Stimulus generator, delay pipeline and counters. Only an exact
  // prescaler==div match advances the stimulus, so lowering div below the
  // current prescaler value lets the prescaler run on until it rolls over.
  // Clear is handled outside the enable branch so it works while frozen,
  // and it wins over a same-cycle increment.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc     <= '0;
      stim_ab   <= 2'd0;
      cycle_cnt <= 32'd0;
      for (int k = 0; k < DELAY; k++) begin
        stage[k] <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        togCnt[i] <= '0;
      end
    end else begin
      if (enable) begin
        if (presc == div) begin
          presc   <= '0;
          stim_ab <= stim_ab + 2'd1;
        end else begin
          presc <= presc + PRESC_ONE;
        end
        stage[0] <= gateVal;
        for (int k = 1; k < DELAY; k++) begin
          stage[k] <= stage[k-1];
        end
      end

      if (clear) begin
        cycle_cnt <= 32'd0;
        for (int i = 0; i < CHANNELS; i++) begin
          togCnt[i] <= '0;
        end
      end else if (enable) begin
        cycle_cnt <= cycle_cnt + 32'd1;
        for (int i = 0; i < CHANNELS; i++) begin
          if ((outNext[i] != gate_out[i]) && (togCnt[i] != {CNT_W{1'b1}})) begin
            togCnt[i] <= togCnt[i] + CNT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_gate_sim.sv
// tb_logic_gate_sim
//   Directed bench for logic_gate_sim (4 channels, DELAY=2, CNT_W=4).
//   Stimulus code pushes hand-computed expectations into a queue; a monitor
//   on the falling edge pops and compares them against the DUT outputs.

module tb_logic_gate_sim;

  localparam int CH  = 4;
  localparam int DLY = 2;
  localparam int CW  = 4;
  localparam int SW  = 16;

  localparam int K_STIM = 0;
  localparam int K_GOUT = 1;
  localparam int K_GBIT = 2;
  localparam int K_TOG  = 3;
  localparam int K_CYC  = 4;

  // ch0 AND, ch1 XOR, ch2 NOT, ch3 NOR
  localparam logic [3*CH-1:0] SEL_A = {3'd4, 3'd0, 3'd5, 3'd1};
  // ch0 BUF, rest as SEL_A
  localparam logic [3*CH-1:0] SEL_S = {3'd4, 3'd0, 3'd5, 3'd7};
  // ch0 OR, ch1 NAND, ch2 XNOR, ch3 NOR
  localparam logic [3*CH-1:0] SEL_O = {3'd4, 3'd6, 3'd3, 3'd2};

  logic              clock = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              clear;
  logic [SW-1:0]     div;
  logic [3*CH-1:0]   gate_sel;
  logic [1:0]        stim_ab;
  logic [CH-1:0]     gate_out;
  logic [CW*CH-1:0]  toggle_cnt;
  logic [31:0]       cycle_cnt;

  typedef struct {
    string       name;
    int          kind;
    int          ch;
    logic [31:0] exp;
  } expect_t;

  expect_t sb[$];
  int vectorsApplied = 0;
  int miscompares    = 0;

  logic [3:0] opTable [4];

  logic_gate_sim #(
    .CHANNELS(CH),
    .DELAY(DLY),
    .CNT_W(CW),
    .STIM_W(SW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .clear(clear),
    .div(div),
    .gate_sel(gate_sel),
    .stim_ab(stim_ab),
    .gate_out(gate_out),
    .toggle_cnt(toggle_cnt),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clock = ~clock;

  // Drive all inputs, then let the given number of rising edges pass;
  // returns 1 time unit after the last edge.
  task automatic applyStimulus(input logic rn, input logic en, input logic clr,
                               input logic [SW-1:0] d, input logic [3*CH-1:0] sel,
                               input int edges);
    reset_n  = rn;
    enable   = en;
    clear    = clr;
    div      = d;
    gate_sel = sel;
    repeat (edges) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Queue an expectation for the monitor to compare on the next falling edge.
  task automatic checkOutput(input string name, input int kind, input int ch,
                             input logic [31:0] exp);
    expect_t e;
    e.name = name;
    e.kind = kind;
    e.ch   = ch;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Monitor: drains every pending expectation mid-cycle, when outputs are stable.
  always @(negedge clock) begin
    expect_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_STIM:  act = {30'd0, stim_ab};
        K_GOUT:  act = {{(32-CH){1'b0}}, gate_out};
        K_GBIT:  act = {31'd0, gate_out[e.ch]};
        K_TOG:   act = {{(32-CW){1'b0}}, toggle_cnt[CW*e.ch +: CW]};
        default: act = cycle_cnt;
      endcase
      vectorsApplied++;
      if (act !== e.exp) begin
        miscompares++;
        $display("[TB] FAIL %s: got %0d, want %0d", e.name, act, e.exp);
      end
    end
  end

  initial begin
    opTable[0] = 4'b1110;
    opTable[1] = 4'b0011;
    opTable[2] = 4'b0011;
    opTable[3] = 4'b0101;

    // Reset held with enable high
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, SEL_A, 3);
    checkOutput("rst_stim", K_STIM, 0, 32'd0);
    checkOutput("rst_gout", K_GOUT, 0, 32'd0);
    checkOutput("rst_tog0", K_TOG, 0, 32'd0);
    checkOutput("rst_tog2", K_TOG, 2, 32'd0);
    checkOutput("rst_cyc", K_CYC, 0, 32'd0);

    // div=0: stimulus steps every cycle, AND pulse lags stim_ab=3 by two
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, SEL_A, 1);
    checkOutput("t2_cyc1", K_CYC, 0, 32'd1);
    checkOutput("t2_stim1", K_STIM, 0, 32'd1);
    checkOutput("t2_gout1", K_GOUT, 0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, SEL_A, 3);
    checkOutput("t2_stim4", K_STIM, 0, 32'd0);
    checkOutput("t2_gout4", K_GOUT, 0, 32'b0110);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, SEL_A, 1);
    checkOutput("t2_and5", K_GBIT, 0, 32'd1);
    checkOutput("t2_stim5", K_STIM, 0, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, SEL_A, 1);
    checkOutput("t2_and6", K_GBIT, 0, 32'd0);
    checkOutput("t2_tog0_6", K_TOG, 0, 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, SEL_A, 2);
    checkOutput("t2_cyc8", K_CYC, 0, 32'd8);
    checkOutput("t2_tog0_8", K_TOG, 0, 32'd2);
    checkOutput("t2_tog2_8", K_TOG, 2, 32'd7);
    checkOutput("t2_not8", K_GBIT, 2, 32'd1);

    // Mid-run reset discards pipeline contents; then div=3 with XOR on ch1
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd3, SEL_A, 1);
    checkOutput("t3_rst_gout", K_GOUT, 0, 32'd0);
    checkOutput("t3_rst_stim", K_STIM, 0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 5);
    checkOutput("t3_stim5", K_STIM, 0, 32'd1);
    checkOutput("t3_xor5", K_GBIT, 1, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 1);
    checkOutput("t3_xor6", K_GBIT, 1, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 4);
    checkOutput("t3_xor10", K_GBIT, 1, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 4);
    checkOutput("t3_xor14", K_GBIT, 1, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 18);
    checkOutput("t3_cyc32", K_CYC, 0, 32'd32);
    checkOutput("t3_stim32", K_STIM, 0, 32'd0);
    checkOutput("t3_xor32", K_GBIT, 1, 32'd0);
    checkOutput("t3_tog1_32", K_TOG, 1, 32'd4);

    // Freeze for 10 cycles with the prescaler mid-slot, then resume
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 1);
    checkOutput("t4_cyc33", K_CYC, 0, 32'd33);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd3, SEL_A, 10);
    checkOutput("t4_frz_stim", K_STIM, 0, 32'd0);
    checkOutput("t4_frz_cyc", K_CYC, 0, 32'd33);
    checkOutput("t4_frz_gout", K_GOUT, 0, 32'b0001);
    checkOutput("t4_frz_tog1", K_TOG, 1, 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 2);
    checkOutput("t4_res_stim35", K_STIM, 0, 32'd0);
    checkOutput("t4_res_cyc35", K_CYC, 0, 32'd35);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 1);
    checkOutput("t4_res_stim36", K_STIM, 0, 32'd1);
    checkOutput("t4_res_cyc36", K_CYC, 0, 32'd36);

    // Clear on the edge where ch1 and ch2 both toggle
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'd3, SEL_A, 1);
    checkOutput("t5_clr_tog1", K_TOG, 1, 32'd0);
    checkOutput("t5_clr_tog2", K_TOG, 2, 32'd0);
    checkOutput("t5_clr_tog0", K_TOG, 0, 32'd0);
    checkOutput("t5_clr_cyc", K_CYC, 0, 32'd0);
    checkOutput("t5_clr_xor", K_GBIT, 1, 32'd1);
    checkOutput("t5_clr_stim", K_STIM, 0, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 1);
    checkOutput("t5_cyc1", K_CYC, 0, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, SEL_A, 7);
    checkOutput("t5_cyc8", K_CYC, 0, 32'd8);
    checkOutput("t5_tog1", K_TOG, 1, 32'd1);
    checkOutput("t5_tog2", K_TOG, 2, 32'd2);
    checkOutput("t5_tog0", K_TOG, 0, 32'd1);
    checkOutput("t5_xor", K_GBIT, 1, 32'd0);

    // Saturation of a 4-bit toggle counter with BUF on ch0
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, SEL_S, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, SEL_S, 100);
    checkOutput("t6_tog0_sat", K_TOG, 0, 32'd15);
    checkOutput("t6_cyc100", K_CYC, 0, 32'd100);

    // Lowering div below the prescaler gives no early match
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd5, SEL_A, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd5, SEL_A, 4);
    checkOutput("t7_stim_pre", K_STIM, 0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd2, SEL_A, 20);
    checkOutput("t7_stim_post", K_STIM, 0, 32'd0);
    checkOutput("t7_cyc24", K_CYC, 0, 32'd24);

    // Remaining ops against all four stimulus values
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, SEL_O, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, SEL_O, 1);
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, SEL_O, 1);
      checkOutput($sformatf("t8_ops_stim%0d", s), K_GOUT, 0, {28'd0, opTable[s]});
    end

    // Let the monitor drain the queue, bounded
    for (int w = 0; w < 4 && sb.size() > 0; w++) begin
      @(negedge clock);
      #1;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
